// File: rtl/cpu_bus_responder_pkg.sv
// Shared types, memory-map constants and the address decoder for the CPU bus responder.
// The decoder is a function so the responder and any future observer agree on one map.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    TgtNone  = 2'd0,
    TgtExt   = 2'd1,
    TgtVideo = 2'd2,
    TgtIo    = 2'd3
  } tgt_sel_e;

  typedef enum logic [2:0] {
    RegExt,
    RegVideo,
    RegUnusable,
    RegIo,
    RegHram
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    AccFwd,
    AccHram,
    AccUnusable,
    AccBlocked
  } access_e;

  localparam logic [15:0] ROM_BASE       = 16'h0000;
  localparam logic [15:0] ROM_LIMIT      = 16'h7FFF;
  localparam logic [15:0] VRAM_BASE      = 16'h8000;
  localparam logic [15:0] VRAM_LIMIT     = 16'h9FFF;
  localparam logic [15:0] EXT_RAM_BASE   = 16'hA000;
  localparam logic [15:0] EXT_RAM_LIMIT  = 16'hBFFF;
  localparam logic [15:0] WRAM_BASE      = 16'hC000;
  localparam logic [15:0] WRAM_LIMIT     = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE      = 16'hE000;
  localparam logic [15:0] ECHO_LIMIT     = 16'hFDFF;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam logic [15:0] OAM_LIMIT      = 16'hFE9F;
  localparam logic [15:0] UNUSABLE_BASE  = 16'hFEA0;
  localparam logic [15:0] UNUSABLE_LIMIT = 16'hFEFF;
  localparam logic [15:0] IO_BASE        = 16'hFF00;
  localparam logic [15:0] IO_LIMIT       = 16'hFF7F;
  localparam logic [15:0] HRAM_BASE      = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT     = 16'hFFFE;
  localparam logic [15:0] IE_BASE        = 16'hFFFF;
  localparam logic [15:0] IE_LIMIT       = 16'hFFFF;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;
  localparam logic [7:0] UNUSABLE_DEFAULT = 8'h00;
  localparam int         HRAM_DEPTH       = 127;

  function automatic logic in_range(input logic [15:0] addr, input logic [15:0] base,
                                    input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

  // First match wins; echo RAM is forwarded to the external block untouched.
  function automatic region_e cpu_bus_decode(input logic [15:0] addr);
    region_e region;
    if (in_range(addr, ROM_BASE, ROM_LIMIT))                region = RegExt;
    else if (in_range(addr, VRAM_BASE, VRAM_LIMIT))         region = RegVideo;
    else if (in_range(addr, EXT_RAM_BASE, EXT_RAM_LIMIT))   region = RegExt;
    else if (in_range(addr, WRAM_BASE, WRAM_LIMIT))         region = RegExt;
    else if (in_range(addr, ECHO_BASE, ECHO_LIMIT))         region = RegExt;
    else if (in_range(addr, OAM_BASE, OAM_LIMIT))           region = RegVideo;
    else if (in_range(addr, UNUSABLE_BASE, UNUSABLE_LIMIT)) region = RegUnusable;
    else if (in_range(addr, IO_BASE, IO_LIMIT))             region = RegIo;
    else if (in_range(addr, HRAM_BASE, HRAM_LIMIT))         region = RegHram;
    else if (in_range(addr, IE_BASE, IE_LIMIT))             region = RegIo;
    else                                                    region = RegExt;
    return region;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side request bus and the single strobe/ready target bus used by the responder.
// On each bus the master modport is the side that originates the access.
interface cpu_bus_if;
  logic [1:0]  t_cycle;
  logic        cpu_mem_enable;
  logic        cpu_mem_write;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_data_in;

  modport master (output t_cycle, cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_wdata,
                  input cpu_data_in);
  modport slave  (input t_cycle, cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_wdata,
                  output cpu_data_in);
endinterface

interface tgt_bus_if;
  import cpu_bus_pkg::*;

  tgt_sel_e    tgt_sel;
  logic        tgt_req;
  logic        tgt_write;
  logic [15:0] tgt_addr;
  logic [7:0]  tgt_wdata;
  logic [7:0]  tgt_rdata;
  logic        tgt_ready;

  modport master (output tgt_sel, tgt_req, tgt_write, tgt_addr, tgt_wdata,
                  input tgt_rdata, tgt_ready);
  modport slave  (input tgt_sel, tgt_req, tgt_write, tgt_addr, tgt_wdata,
                  output tgt_rdata, tgt_ready);
endinterface

// File: rtl/cpu_bus_responder_hram.sv
// 127x8 high RAM: synchronous write, asynchronous read, contents survive reset.
module cpu_hram
  import cpu_bus_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [HRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_bus_responder.sv
// Responder for the CPU memory interface: one request per M-cycle, HRAM served locally,
// everything else forwarded over the target bus with DMA lockout and timeout handling.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS_VALUE = OPEN_BUS_DEFAULT,
  parameter logic [7:0] UNUSABLE_VALUE = UNUSABLE_DEFAULT,
  parameter bit         DMA_LOCK_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  cpu_bus_if.slave   cpuIf,
  tgt_bus_if.master  tgtIf,
  input  logic       dma_active,
  output logic       timeout_err,
  output logic       dma_conflict,
  input  logic       err_clear
);

  state_e      state_q;
  access_e     kind_q;
  logic        write_q;
  logic        captured_q;
  logic [7:0]  rdata_q;
  logic [7:0]  cpuData_q;
  tgt_sel_e    tgtSel_q;
  logic        tgtReq_q;
  logic        tgtWrite_q;
  logic [15:0] tgtAddr_q;
  logic [7:0]  tgtWdata_q;
  logic        timeoutErr_q;
  logic        dmaConflict_q;

  region_e     capRegion;
  logic        capLocked;
  access_e     capKind_d;
  tgt_sel_e    capSel_d;
  logic        hramWe;
  logic [7:0]  hramRdata;

  always_comb begin
    capRegion = cpu_bus_decode(cpuIf.cpu_addr);
    capLocked = DMA_LOCK_EN && dma_active && (capRegion != RegHram) && (capRegion != RegIo);
    capKind_d = AccFwd;
    capSel_d  = TgtNone;
    if (capLocked) begin
      capKind_d = AccBlocked;
    end else begin
      unique case (capRegion)
        RegHram:     capKind_d = AccHram;
        RegUnusable: capKind_d = AccUnusable;
        RegVideo:    capSel_d  = TgtVideo;
        RegIo:       capSel_d  = TgtIo;
        default:     capSel_d  = TgtExt;
      endcase
    end
  end

  // HRAM writes commit at the end of the in-sequence ISSUE clock only.
  assign hramWe = (state_q == StIssue) && (cpuIf.t_cycle == 2'd1) &&
                  (kind_q == AccHram) && write_q;

  cpu_hram uHram (
    .clk   (clk),
    .we    (hramWe),
    .waddr (tgtAddr_q[6:0]),
    .wdata (tgtWdata_q),
    .raddr (tgtAddr_q[6:0]),
    .rdata (hramRdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      kind_q        <= AccFwd;
      write_q       <= 1'b0;
      captured_q    <= 1'b0;
      rdata_q       <= 8'h00;
      cpuData_q     <= OPEN_BUS_VALUE;
      tgtSel_q      <= TgtNone;
      tgtReq_q      <= 1'b0;
      tgtWrite_q    <= 1'b0;
      tgtAddr_q     <= 16'h0000;
      tgtWdata_q    <= 8'h00;
      timeoutErr_q  <= 1'b0;
      dmaConflict_q <= 1'b0;
    end else begin
      tgtReq_q <= 1'b0;
      // Clearing comes first so a same-clock set below overrides it.
      if (err_clear) begin
        timeoutErr_q  <= 1'b0;
        dmaConflict_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if ((cpuIf.t_cycle == 2'd0) && cpuIf.cpu_mem_enable) begin
            state_q    <= StIssue;
            kind_q     <= capKind_d;
            write_q    <= cpuIf.cpu_mem_write;
            captured_q <= 1'b0;
            tgtAddr_q  <= cpuIf.cpu_addr;
            tgtWdata_q <= cpuIf.cpu_wdata;
            tgtSel_q   <= capSel_d;
            tgtReq_q   <= (capKind_d == AccFwd);
            tgtWrite_q <= (capKind_d == AccFwd) && cpuIf.cpu_mem_write;
            if (capKind_d == AccBlocked) begin
              dmaConflict_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (cpuIf.t_cycle != 2'd1) begin
            state_q    <= StIdle;
            tgtSel_q   <= TgtNone;
            tgtWrite_q <= 1'b0;
          end else begin
            state_q <= StWait;
            if (kind_q == AccHram) begin
              rdata_q    <= hramRdata;
              captured_q <= 1'b1;
            end else if ((kind_q == AccFwd) && tgtIf.tgt_ready) begin
              rdata_q    <= tgtIf.tgt_rdata;
              captured_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (cpuIf.t_cycle != 2'd2) begin
            state_q    <= StIdle;
            tgtSel_q   <= TgtNone;
            tgtWrite_q <= 1'b0;
          end else begin
            state_q <= StDone;
            // Read data is loaded here so it is stable for the whole of t3.
            unique case (kind_q)
              AccFwd: begin
                if (captured_q) begin
                  if (!write_q) cpuData_q <= rdata_q;
                end else if (tgtIf.tgt_ready) begin
                  if (!write_q) cpuData_q <= tgtIf.tgt_rdata;
                end else begin
                  timeoutErr_q <= 1'b1;
                  if (!write_q) cpuData_q <= OPEN_BUS_VALUE;
                end
              end
              AccHram: begin
                if (!write_q) cpuData_q <= rdata_q;
              end
              AccUnusable: begin
                if (!write_q) cpuData_q <= UNUSABLE_VALUE;
              end
              default: begin
                if (!write_q) cpuData_q <= OPEN_BUS_VALUE;
              end
            endcase
          end
        end
        default: begin
          state_q    <= StIdle;
          tgtSel_q   <= TgtNone;
          tgtWrite_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpuIf.cpu_data_in = cpuData_q;
  assign tgtIf.tgt_sel     = tgtSel_q;
  assign tgtIf.tgt_req     = tgtReq_q;
  assign tgtIf.tgt_write   = tgtWrite_q;
  assign tgtIf.tgt_addr    = tgtAddr_q;
  assign tgtIf.tgt_wdata   = tgtWdata_q;
  assign timeout_err       = timeoutErr_q;
  assign dma_conflict      = dmaConflict_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: directed vector table, multi-cycle corner sequences and
// randomized M-cycles checked against a memory-map level reference model.
module tb_cpu_bus_responder;
  import cpu_bus_pkg::*;

  localparam int RExt = 0, RVideo = 1, RUnusable = 2, RIo = 3, RHram = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic dma_active;
  logic err_clear;
  logic timeout_err;
  logic dma_conflict;

  always #5 clk = ~clk;

  cpu_bus_if cpuIf ();
  tgt_bus_if tgtIf ();

  cpu_bus_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpuIf        (cpuIf),
    .tgtIf        (tgtIf),
    .dma_active   (dma_active),
    .timeout_err  (timeout_err),
    .dma_conflict (dma_conflict),
    .err_clear    (err_clear)
  );

  typedef struct {
    int          reqCount;
    logic        reqT1;
    tgt_sel_e    selT1;
    logic [15:0] addrT1;
    logic        writeT1;
    tgt_sel_e    selT2;
    logic [15:0] addrT2;
    logic [7:0]  dataT3;
    logic        toT3;
    logic        dcT3;
  } obs_t;

  typedef struct {
    logic       req;
    tgt_sel_e   sel;
    logic [7:0] data;
    logic       to;
    logic       dc;
  } exp_t;

  typedef struct {
    logic        clr;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        dma;
    logic [1:0]  rdy;
    logic [7:0]  rdat;
    logic        req;
    tgt_sel_e    sel;
    logic [7:0]  data;
    logic        to;
    logic        dc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] mHram [127];
  logic [7:0] mData;
  logic       mTo;
  logic       mDc;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic int regionOf(input logic [15:0] a);
    if (a < 16'h8000) return RExt;
    if (a < 16'hA000) return RVideo;
    if (a < 16'hFE00) return RExt;
    if (a < 16'hFEA0) return RVideo;
    if (a < 16'hFF00) return RUnusable;
    if (a < 16'hFF80) return RIo;
    if (a == 16'hFFFF) return RIo;
    return RHram;
  endfunction

  // Reference model: what the CPU should see for one whole M-cycle.
  task automatic modelAccess(input logic clr, input logic wr, input logic [15:0] addr,
                             input logic [7:0] wd, input logic dma, input logic [1:0] rdy,
                             input logic [7:0] rdat, output exp_t e);
    int r;
    r = regionOf(addr);
    e.req = 1'b0;
    e.sel = TgtNone;
    if (clr) begin
      mTo = 1'b0;
      mDc = 1'b0;
    end
    if (dma && r != RHram && r != RIo) begin
      mDc = 1'b1;
      if (!wr) mData = 8'hFF;
    end else if (r == RUnusable) begin
      if (!wr) mData = 8'h00;
    end else if (r == RHram) begin
      if (wr) mHram[addr - 16'hFF80] = wd;
      else    mData = mHram[addr - 16'hFF80];
    end else begin
      e.req = 1'b1;
      e.sel = (r == RVideo) ? TgtVideo : ((r == RIo) ? TgtIo : TgtExt);
      if (rdy != 2'b00) begin
        if (!wr) mData = rdat;
      end else begin
        mTo = 1'b1;
        if (!wr) mData = 8'hFF;
      end
    end
    e.data = mData;
    e.to   = mTo;
    e.dc   = mDc;
  endtask

  task automatic driveT(input logic [1:0] t, input logic en, input logic wr,
                        input logic [15:0] addr, input logic [7:0] wd, input logic dma,
                        input logic clr, input logic rdy, input logic [7:0] rdat);
    @(negedge clk);
    cpuIf.t_cycle        = t;
    cpuIf.cpu_mem_enable = en;
    cpuIf.cpu_mem_write  = wr;
    cpuIf.cpu_addr       = addr;
    cpuIf.cpu_wdata      = wd;
    dma_active           = dma;
    err_clear            = clr;
    tgtIf.tgt_ready      = rdy;
    tgtIf.tgt_rdata      = rdy ? rdat : 8'hEE;
    #1;
  endtask

  task automatic applyStimulus(input logic clr, input logic wr, input logic [15:0] addr,
                               input logic [7:0] wd, input logic dma, input logic [1:0] rdy,
                               input logic [7:0] rdat, output obs_t o);
    o.reqCount = 0;
    o.reqT1 = 1'b0; o.selT1 = TgtNone; o.addrT1 = '0; o.writeT1 = 1'b0;
    o.selT2 = TgtNone; o.addrT2 = '0; o.dataT3 = '0; o.toT3 = 1'b0; o.dcT3 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      driveT(2'(t), (t == 0), wr, addr, wd, dma, clr && (t == 0),
             (t == 1 && rdy[0]) || (t == 2 && rdy[1]), rdat);
      if (tgtIf.tgt_req) o.reqCount++;
      if (t == 1) begin
        o.reqT1 = tgtIf.tgt_req; o.selT1 = tgtIf.tgt_sel;
        o.addrT1 = tgtIf.tgt_addr; o.writeT1 = tgtIf.tgt_write;
      end
      if (t == 2) begin
        o.selT2 = tgtIf.tgt_sel; o.addrT2 = tgtIf.tgt_addr;
      end
      if (t == 3) begin
        o.dataT3 = cpuIf.cpu_data_in; o.toT3 = timeout_err; o.dcT3 = dma_conflict;
      end
    end
  endtask

  task automatic compareAccess(input string tag, input obs_t o, input exp_t e,
                               input logic wr, input logic [15:0] addr);
    checkOutput({tag, " req count"}, o.reqCount, e.req ? 1 : 0);
    checkOutput({tag, " sel t1"}, o.selT1, e.sel);
    if (e.req) begin
      checkOutput({tag, " req at t1"}, o.reqT1, 1'b1);
      checkOutput({tag, " addr t1"}, o.addrT1, addr);
      checkOutput({tag, " write t1"}, o.writeT1, wr);
      checkOutput({tag, " sel held t2"}, o.selT2, e.sel);
      checkOutput({tag, " addr held t2"}, o.addrT2, addr);
    end
    checkOutput({tag, " data t3"}, o.dataT3, e.data);
    checkOutput({tag, " timeout_err"}, o.toT3, e.to);
    checkOutput({tag, " dma_conflict"}, o.dcT3, e.dc);
  endtask

  vec_t vecs [16];

  task automatic runTable();
    obs_t o;
    exp_t e;
    exp_t m;
    vecs[0]  = '{1'b0, 1'b1, 16'hFF90, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, TgtNone,  8'hFF, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'hFF90, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, TgtNone,  8'h5A, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'hFF80, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, TgtNone,  8'h5A, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'hC123, 8'h00, 1'b0, 2'd2, 8'h3C, 1'b1, TgtExt,   8'h3C, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 16'h8000, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, TgtVideo, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'hFEB0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, TgtNone,  8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'hFEB0, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, TgtNone,  8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'hFEB0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, TgtNone,  8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'hC000, 8'h00, 1'b1, 2'd2, 8'h55, 1'b0, TgtNone,  8'hFF, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'hFF80, 8'h00, 1'b1, 2'd0, 8'h00, 1'b0, TgtNone,  8'hA5, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'hFF44, 8'h00, 1'b1, 2'd1, 8'h91, 1'b1, TgtIo,    8'h91, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 16'hA000, 8'h12, 1'b0, 2'd1, 8'h00, 1'b1, TgtExt,   8'h91, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b0, 2'd2, 8'h0F, 1'b1, TgtIo,    8'h0F, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'hD000, 8'h34, 1'b0, 2'd0, 8'h00, 1'b1, TgtExt,   8'h0F, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 16'hFE10, 8'h00, 1'b1, 2'd0, 8'h00, 1'b0, TgtNone,  8'hFF, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 16'hE123, 8'h00, 1'b0, 2'd3, 8'h44, 1'b1, TgtExt,   8'h44, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].dma,
                    vecs[i].rdy, vecs[i].rdat, o);
      modelAccess(vecs[i].clr, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].dma,
                  vecs[i].rdy, vecs[i].rdat, m);
      e.req = vecs[i].req; e.sel = vecs[i].sel; e.data = vecs[i].data;
      e.to = vecs[i].to;   e.dc = vecs[i].dc;
      compareAccess($sformatf("vec%0d", i), o, e, vecs[i].wr, vecs[i].addr);
    end
  endtask

  task automatic resetMidAccess();
    int reqs;
    obs_t o;
    exp_t e;
    reqs = 0;
    driveT(2'd0, 1'b1, 1'b0, 16'hC123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    driveT(2'd1, 1'b0, 1'b0, 16'hC123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("midreset req t1", tgtIf.tgt_req, 1'b1);
    driveT(2'd2, 1'b0, 1'b0, 16'hC123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset req", tgtIf.tgt_req, 1'b0);
    checkOutput("midreset sel", tgtIf.tgt_sel, TgtNone);
    checkOutput("midreset addr", tgtIf.tgt_addr, 16'h0000);
    checkOutput("midreset data", cpuIf.cpu_data_in, 8'hFF);
    checkOutput("midreset timeout_err", timeout_err, 1'b0);
    checkOutput("midreset dma_conflict", dma_conflict, 1'b0);
    driveT(2'd3, 1'b0, 1'b0, 16'hC123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int t = 0; t < 4; t++) begin
        driveT(2'(t), (t != 0), 1'b0, 16'hC123, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66);
        if (tgtIf.tgt_req) reqs++;
      end
    end
    checkOutput("post-reset stray req count", reqs, 0);
    mData = 8'hFF; mTo = 1'b0; mDc = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'hFF90, 8'h00, 1'b0, 2'd2, 8'h11, o);
    modelAccess(1'b0, 1'b0, 16'hFF90, 8'h00, 1'b0, 2'd2, 8'h11, e);
    compareAccess("post-reset hram", o, e, 1'b0, 16'hFF90);
  endtask

  task automatic outOfSequence();
    obs_t o;
    exp_t e;
    driveT(2'd0, 1'b1, 1'b0, 16'hC200, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    driveT(2'd0, 1'b0, 1'b0, 16'hC200, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("oos req in issue", tgtIf.tgt_req, 1'b1);
    driveT(2'd1, 1'b0, 1'b0, 16'hC200, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("oos sel after abort", tgtIf.tgt_sel, TgtNone);
    checkOutput("oos req after abort", tgtIf.tgt_req, 1'b0);
    driveT(2'd2, 1'b0, 1'b0, 16'hC200, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    driveT(2'd3, 1'b0, 1'b0, 16'hC200, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("oos data kept", cpuIf.cpu_data_in, mData);
    checkOutput("oos no timeout", timeout_err, mTo);
    applyStimulus(1'b0, 1'b0, 16'hC200, 8'h00, 1'b0, 2'd2, 8'h6B, o);
    modelAccess(1'b0, 1'b0, 16'hC200, 8'h00, 1'b0, 2'd2, 8'h6B, e);
    compareAccess("oos recover", o, e, 1'b0, 16'hC200);
  endtask

  function automatic logic [15:0] randomAddr();
    case ($urandom_range(0, 7))
      0:       return 16'($urandom);
      1:       return 16'hFF80 + 16'($urandom_range(0, 126));
      2:       return 16'hFF00 + 16'($urandom_range(0, 127));
      3:       return 16'hFFFF;
      4:       return 16'hFEA0 + 16'($urandom_range(0, 95));
      5:       return 16'hFE00 + 16'($urandom_range(0, 159));
      6:       return 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
      default: return 16'hA000 + 16'($urandom_range(0, 16'h5DFF));
    endcase
  endfunction

  task automatic runRandom();
    obs_t o;
    exp_t e;
    logic clr, wr, dma;
    logic [15:0] addr;
    logic [7:0] wd, rdat;
    logic [1:0] rdy;
    for (int i = 0; i < 127; i++) begin
      addr = 16'hFF80 + 16'(i);
      wd = 8'($urandom);
      applyStimulus(1'b0, 1'b1, addr, wd, 1'b0, 2'd0, 8'h00, o);
      modelAccess(1'b0, 1'b1, addr, wd, 1'b0, 2'd0, 8'h00, e);
      compareAccess($sformatf("hinit%0d", i), o, e, 1'b1, addr);
    end
    for (int i = 0; i < 200; i++) begin
      clr  = ($urandom_range(0, 7) == 0);
      wr   = ($urandom_range(0, 2) == 0);
      dma  = ($urandom_range(0, 3) == 0);
      addr = randomAddr();
      wd   = 8'($urandom);
      rdat = 8'($urandom);
      rdy  = 2'($urandom_range(0, 3));
      applyStimulus(clr, wr, addr, wd, dma, rdy, rdat, o);
      modelAccess(clr, wr, addr, wd, dma, rdy, rdat, e);
      compareAccess($sformatf("rnd%0d@%h", i, addr), o, e, wr, addr);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n              = 1'b0;
    cpuIf.t_cycle        = 2'd0;
    cpuIf.cpu_mem_enable = 1'b0;
    cpuIf.cpu_mem_write  = 1'b0;
    cpuIf.cpu_addr       = 16'h0000;
    cpuIf.cpu_wdata      = 8'h00;
    dma_active           = 1'b0;
    err_clear            = 1'b0;
    tgtIf.tgt_ready      = 1'b0;
    tgtIf.tgt_rdata      = 8'h00;
    mData = 8'hFF; mTo = 1'b0; mDc = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset data", cpuIf.cpu_data_in, 8'hFF);
    checkOutput("reset req", tgtIf.tgt_req, 1'b0);
    checkOutput("reset write", tgtIf.tgt_write, 1'b0);
    checkOutput("reset sel", tgtIf.tgt_sel, TgtNone);
    checkOutput("reset addr", tgtIf.tgt_addr, 16'h0000);
    checkOutput("reset wdata", tgtIf.tgt_wdata, 8'h00);
    checkOutput("reset timeout_err", timeout_err, 1'b0);
    checkOutput("reset dma_conflict", dma_conflict, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    runTable();
    resetMidAccess();
    outOfSequence();
    runRandom();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Responder end of the CPU memory interface that cpu_control drives (mem_enable, mem_write, address, write data). It returns mem_data_in, which cpu_control samples at the clock edge ending t_cycle 3.
- Latches one request per M-cycle and decodes the address to a target. Serves HRAM internally and forwards all other accesses over a single strobe/ready target bus to the ext, video and io blocks.
- Enforces OAM-DMA lockout and open-bus/timeout values.

Parameters:
- OPEN_BUS_VALUE, 8'hFF: read data on timeout, DMA lockout, or a blocked access.
- UNUSABLE_VALUE, 8'h00: read data for FEA0-FEFF.
- DMA_LOCK_EN, 1: 1 enables the DMA lockout rule.

Ports:
- clk  in  1  clock; one clk per T-cycle.
- reset_n  in  1  asynchronous, active-low reset.
- t_cycle  in  2  T-cycle index, 0..3.
- cpu_mem_enable  in  1  CPU access request, valid at t_cycle 0.
- cpu_mem_write  in  1  1 = write.
- cpu_addr  in  16  access address.
- cpu_wdata  in  8  write data.
- cpu_data_in  out  8  read data returned to the CPU.
- dma_active  in  1  OAM DMA in progress.
- tgt_sel  out  2  tgt_sel_e: TgtNone, TgtExt, TgtVideo, TgtIo.
- tgt_req  out  1  one-clk access strobe.
- tgt_write  out  1  write qualifier for tgt_req.
- tgt_addr  out  16  target address.
- tgt_wdata  out  8  target write data.
- tgt_rdata  in  8  target read data (muxed externally).
- tgt_ready  in  1  target completion; may be combinational with tgt_req.
- timeout_err  out  1  sticky: a target missed its deadline.
- dma_conflict  out  1  sticky: an access was blocked by DMA.
- err_clear  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async assert, sync release):
  - cpu_data_in = OPEN_BUS_VALUE.
  - tgt_req = 0, tgt_write = 0, tgt_sel = TgtNone, tgt_addr = 0, tgt_wdata = 0.
  - timeout_err = 0, dma_conflict = 0.
  - FSM = IDLE.
  - HRAM contents are not cleared.
- Request capture: only in a clk with t_cycle==0 and FSM==IDLE and cpu_mem_enable=1. The responder then latches addr, write and wdata. cpu_mem_enable is ignored at t_cycle 1-3.
- Decode, first match wins:
  - 0000-7FFF, A000-FDFF → TgtExt. Echo RAM is passed unmodified.
  - 8000-9FFF, FE00-FE9F → TgtVideo.
  - FEA0-FEFF → unusable. Reads return UNUSABLE_VALUE; writes are dropped; no strobe.
  - FF00-FF7F, FFFF → TgtIo.
  - FF80-FFFE → HRAM (127x8, index addr-FF80).
- DMA lockout (DMA_LOCK_EN=1 and dma_active at capture):
  - Only HRAM and Io accesses proceed.
  - Any other access: no tgt_req; reads return OPEN_BUS_VALUE; writes are dropped; dma_conflict is set.
- FSM, one state per T-cycle:
  - IDLE → ISSUE on capture.
  - ISSUE (t1): for forwarded accesses, tgt_req=1 for exactly this clk, with tgt_sel/addr/write/wdata valid. If tgt_ready=1 this clk, capture tgt_rdata.
    - HRAM read: capture array data.
    - HRAM write: commit at the end of this clk.
  - WAIT (t2): tgt_sel/addr/wdata are held and tgt_req=0. If not yet captured and tgt_ready=1, capture. If still uncaptured at the end of t2, the access times out: data = OPEN_BUS_VALUE, timeout_err set. A write that times out is counted as dropped.
  - DONE (t3): cpu_data_in drives the captured read value for the whole clk. → IDLE at the end of t3; tgt_sel → TgtNone.
- tgt_ready is ignored outside ISSUE/WAIT. An extra ready is not an error.
- cpu_data_in holds its last value between accesses. A write access leaves it unchanged.
- Sticky flags:
  - Set takes priority over err_clear in the same clk.
  - timeout_err and dma_conflict assert 1 clk after the event.
- If t_cycle is observed out of sequence relative to the FSM (e.g. t_cycle==0 while in WAIT), force IDLE without returning data, then capture normally on the next t_cycle 0.
- reset_n asserted mid-access: abort immediately. No tgt_req is issued after release until a new t_cycle 0 capture. An HRAM write not yet committed is lost.

Decomposition:
- Package cpu_bus_pkg:
  - tgt_sel_e.
  - Region base/limit constants: ROM, VRAM, EXT_RAM, WRAM, ECHO, OAM, UNUSABLE, IO, HRAM, IE.
  - OPEN_BUS default.
- Sub-module cpu_hram: 127x8 synchronous-write, asynchronous-read array with we, waddr, wdata, raddr, rdata.
- Decode is a function in the package, not a separate module.

Test Plan:
- HRAM round trip: write FF90←5A in M-cycle 1, read FF90 in M-cycle 2 → tgt_req never asserted; cpu_data_in=5A during t3 of the read.
- Ext read, ready in t2: read C123, tgt_ready=1 with tgt_rdata=3C in the WAIT clk → tgt_req exactly 1 clk at t1, tgt_sel=TgtExt, tgt_addr=C123; cpu_data_in=3C at t3; timeout_err=0.
- Timeout: read 8000 with tgt_ready held 0 → tgt_sel=TgtVideo; cpu_data_in=FF at t3; timeout_err=1; err_clear pulse → 0.
- DMA lockout:
  - dma_active=1, read C000 → no tgt_req; data FF; dma_conflict=1.
  - Then read FF80 → HRAM value returned normally.
  - Then read FF44 → tgt_req with TgtIo.
- Unusable region: read FEB0 → cpu_data_in=00, no strobe; write FEB0←77 then read FEB0 → 00.
- Reset mid-access: assert reset_n=0 during WAIT of an ext read → outputs reach reset values asynchronously; after release, no tgt_req until the next t_cycle 0 with cpu_mem_enable=1.
